// File: rtl/qtable_update_ctrl.sv
// Front-end sequencer for the Q-table update engine: filters RX packets by type,
// buffers them in a small FIFO and runs the engine one packet at a time with a watchdog.
module qtable_update_ctrl #(
    parameter int         WORD_WIDTH = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TYPE_MASK  = 8'b0000_0110,
    parameter int         TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    input  logic [WORD_WIDTH-1:0]         pkt_source_id,
    input  logic [WORD_WIDTH-1:0]         pkt_hops,
    input  logic [WORD_WIDTH-1:0]         pkt_cluster_id,
    input  logic [WORD_WIDTH-1:0]         pkt_energy,
    input  logic [WORD_WIDTH-1:0]         pkt_qvalue,
    input  logic [WORD_WIDTH-1:0]         pkt_known_ch,
    input  logic [2:0]                    pkt_type,
    output logic [WORD_WIDTH-1:0]         f_source_id,
    output logic [WORD_WIDTH-1:0]         f_hops,
    output logic [WORD_WIDTH-1:0]         f_cluster_id,
    output logic [WORD_WIDTH-1:0]         f_energy,
    output logic [WORD_WIDTH-1:0]         f_qvalue,
    output logic [WORD_WIDTH-1:0]         f_known_ch,
    output logic [2:0]                    f_type,
    output logic                          upd_en,
    input  logic                          upd_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [WORD_WIDTH-1:0]         drop_count,
    output logic                          timeout_err,
    input  logic                          timeout_clr
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [2:0]            ptype;
        logic [WORD_WIDTH-1:0] source_id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] cluster_id;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] qvalue;
        logic [WORD_WIDTH-1:0] known_ch;
    } pkt_t;

    typedef enum logic [2:0] {IDLE, LOAD, START, ARM, WAIT} state_t;

    state_t                state_q, state_d;
    pkt_t                  mem_q [FIFO_DEPTH];
    pkt_t                  mem_d [FIFO_DEPTH];
    pkt_t                  head_q, head_d;
    pkt_t                  in_pkt;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  upd_en_q, upd_en_d;
    logic [WORD_WIDTH-1:0] drop_q, drop_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic                  terr_q, terr_d;
    logic                  xfer, accept, push, pop, wd_expire;

    always_comb begin
        in_pkt    = '{ptype: pkt_type, source_id: pkt_source_id, hops: pkt_hops,
                      cluster_id: pkt_cluster_id, energy: pkt_energy,
                      qvalue: pkt_qvalue, known_ch: pkt_known_ch};
        xfer      = pkt_valid && ready_q;
        accept    = TYPE_MASK[pkt_type];
        push      = xfer && accept;
        pop       = (state_q == LOAD);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        head_d    = head_q;
        drop_d    = drop_q;
        wd_d      = wd_q;
        wd_expire = 1'b0;
        state_d   = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_pkt;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            head_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (count_d != CW'(FIFO_DEPTH));

        if (xfer && !accept && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        // IDLE also reacts to a push in flight so a fresh packet reaches LOAD the next cycle
        case (state_q)
            IDLE:  if (count_q != '0 || push) state_d = LOAD;
            LOAD:  state_d = START;
            START: begin
                wd_d    = '0;
                state_d = ARM;
            end
            ARM:   state_d = WAIT;
            WAIT: begin
                if (upd_done) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WDW'(TIMEOUT)) begin
                        wd_expire = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        upd_en_d = (state_d == START);
        terr_d   = timeout_clr ? 1'b0 : (terr_q | wd_expire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            upd_en_q <= 1'b0;
            drop_q   <= '0;
            wd_q     <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            upd_en_q <= upd_en_d;
            drop_q   <= drop_d;
            wd_q     <= wd_d;
            terr_q   <= terr_d;
        end
    end

    assign pkt_ready    = ready_q;
    assign f_source_id  = head_q.source_id;
    assign f_hops       = head_q.hops;
    assign f_cluster_id = head_q.cluster_id;
    assign f_energy     = head_q.energy;
    assign f_qvalue     = head_q.qvalue;
    assign f_known_ch   = head_q.known_ch;
    assign f_type       = head_q.ptype;
    assign upd_en       = upd_en_q;
    assign busy         = (state_q != IDLE);
    assign fifo_count   = count_q;
    assign drop_count   = drop_q;
    assign timeout_err  = terr_q;

endmodule
